// File: rtl/signal_capture_pkg.sv
// signal_capture_pkg
//   Shared definitions for the signal_capture block: FSM state encodings,
//   default widths and a small state-decode helper.
//   No ports (package).
package signal_capture_pkg;

  // FSM state encodings (2-bit, legacy-compatible constants)
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Default widths
  localparam int DEF_NB_DATA  = 8;
  localparam int DEF_NB_ADDR  = 10;
  localparam int DEF_NB_DECIM = 4;

  // Busy covers waiting for the trigger and the capture itself
  function automatic logic state_is_busy(input logic [1:0] st);
    return (st == ST_ARMED) || (st == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/capture_bram.sv
// capture_bram
//   Simple dual-port RAM holding the capture window. One write port and one
//   registered read port, written so that synthesis maps the array to BRAM.
//   A read and a write to the same address in one cycle returns the old data.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (output regs only)
//   we, wr_addr,    write port
//   wr_data
//   rd_en, rd_addr  read request
//   rd_data         registered read data, holds when rd_en=0
//   rd_valid        rd_data updated this cycle (rd_en delayed by one)
module capture_bram #(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [NB_ADDR-1:0] wr_addr,
  input  logic [NB_DATA-1:0] wr_data,
  input  logic               rd_en,
  input  logic [NB_ADDR-1:0] rd_addr,
  output logic [NB_DATA-1:0] rd_data,
  output logic               rd_valid
);

  localparam int DEPTH = 2 ** NB_ADDR;

  // Contents are never cleared; reset only touches the output registers.
  logic [NB_DATA-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Non-blocking write above means a same-cycle read sees the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/signal_capture.sv
// signal_capture
//   Records a fixed-length window (2**NB_ADDR samples) of the signed sample
//   stream into a BRAM after a trigger, with optional 1-of-(N+1) decimation,
//   and exposes a registered read port for readback.
//   Optional feature macro: SIGNAL_CAPTURE_LEVEL_TRIG_EN
//     defined   -> trigger is a signed rising crossing of i_level
//     undefined -> trigger is i_trigger (i_level unused)
// Ports:
//   i_clock, i_reset   clock, asynchronous active-high reset
//   i_sample, i_valid  input sample stream
//   i_arm              pulse: clear counters, latch i_decim, go ARMED
//   i_trigger          start capture (default build)
//   i_level            signed threshold (level-trigger build)
//   i_decim            store 1 of every (i_decim+1) valid samples
//   i_rd_en, i_rd_addr read request
//   o_rd_data          registered read data
//   o_rd_valid         o_rd_data valid
//   o_busy, o_done     registered state decodes
//   o_wr_count         samples stored in the current window
module signal_capture
  import signal_capture_pkg::*;
#(
  parameter int NB_DATA  = DEF_NB_DATA,
  parameter int NB_ADDR  = DEF_NB_ADDR,
  parameter int NB_DECIM = DEF_NB_DECIM
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NB_DATA-1:0]  i_sample,
  input  logic                i_valid,
  input  logic                i_arm,
  input  logic                i_trigger,
  input  logic [NB_DATA-1:0]  i_level,
  input  logic [NB_DECIM-1:0] i_decim,
  input  logic                i_rd_en,
  input  logic [NB_ADDR-1:0]  i_rd_addr,
  output logic [NB_DATA-1:0]  o_rd_data,
  output logic                o_rd_valid,
  output logic                o_busy,
  output logic                o_done,
  output logic [NB_ADDR:0]    o_wr_count
);

  logic [1:0]          state, state_nxt;
  logic [NB_DECIM-1:0] decim_cnt, decim_ratio;
  logic [NB_ADDR-1:0]  wr_addr;
  logic                trigger_event;
  logic                in_window, accept, we, last_write;

  // Count value just before the final write of the window
  logic [NB_ADDR:0] last_cnt;
  assign last_cnt = {1'b0, {NB_ADDR{1'b1}}};

`ifdef SIGNAL_CAPTURE_LEVEL_TRIG_EN
  logic [NB_DATA-1:0] prev;
  logic               unused_trigger;
  assign unused_trigger = i_trigger;

  // prev tracks the last valid sample in every state so a crossing can be
  // detected on the very first valid sample after arming.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)      prev <= '0;
    else if (i_valid) prev <= i_sample;
  end

  assign trigger_event = i_valid
                      && ($signed(prev) < $signed(i_level))
                      && ($signed(i_sample) >= $signed(i_level));
`else
  logic unused_level;
  assign unused_level  = ^i_level;
  assign trigger_event = i_trigger;
`endif

  // The trigger cycle itself belongs to the window. i_arm overrides
  // everything: no write and no decimation step on an arm cycle.
  assign in_window  = ((state == ST_ARMED) && trigger_event) || (state == ST_CAPTURE);
  assign accept     = i_valid && in_window && !i_arm;
  assign we         = accept && (decim_cnt == '0);
  assign last_write = we && (o_wr_count == last_cnt);

  always_comb begin
    state_nxt = state;
    if (i_arm)                                   state_nxt = ST_ARMED;
    else if (last_write)                         state_nxt = ST_DONE;
    else if ((state == ST_ARMED) && trigger_event) state_nxt = ST_CAPTURE;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state  <= ST_IDLE;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_busy <= state_is_busy(state_nxt);
      o_done <= (state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      decim_cnt   <= '0;
      decim_ratio <= '0;
    end else if (i_arm) begin
      decim_cnt   <= '0;
      decim_ratio <= i_decim;
    end else if (accept) begin
      decim_cnt <= (decim_cnt == decim_ratio) ? '0 : decim_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_addr    <= '0;
      o_wr_count <= '0;
    end else if (i_arm) begin
      wr_addr    <= '0;
      o_wr_count <= '0;
    end else if (we) begin
      wr_addr    <= wr_addr + 1'b1;
      o_wr_count <= o_wr_count + 1'b1;
    end
  end

  capture_bram #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_bram (
    .clk      (i_clock),
    .rst      (i_reset),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (i_sample),
    .rd_en    (i_rd_en),
    .rd_addr  (i_rd_addr),
    .rd_data  (o_rd_data),
    .rd_valid (o_rd_valid)
  );

endmodule

// File: tb/tb_signal_capture.sv
// tb_signal_capture
//   Scoreboard bench for signal_capture (NB_ADDR=4, depth 16). Read requests
//   push their expected word; a negedge monitor pops on o_rd_valid.
//   Status outputs are checked directly after each clock edge.
module tb_signal_capture;
  localparam int NB_DATA  = 8;
  localparam int NB_ADDR  = 4;
  localparam int NB_DECIM = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NB_DATA-1:0]  sample;
  logic                valid, arm, trigger;
  logic [NB_DATA-1:0]  level;
  logic [NB_DECIM-1:0] decim;
  logic                rd_en;
  logic [NB_ADDR-1:0]  rd_addr;
  logic [NB_DATA-1:0]  rd_data;
  logic                rd_valid, busy, done;
  logic [NB_ADDR:0]    wr_count;

  always #5 clk = ~clk;

  signal_capture #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_DECIM(NB_DECIM)) dut (
    .i_clock(clk), .i_reset(rst), .i_sample(sample), .i_valid(valid),
    .i_arm(arm), .i_trigger(trigger), .i_level(level), .i_decim(decim),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_rd_valid(rd_valid), .o_busy(busy), .o_done(done), .o_wr_count(wr_count)
  );

  int n_pass = 0;
  int n_total = 0;

  typedef struct { logic [7:0] data; int addr; } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every presented read word is compared with the oldest request
  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb.size() == 0) begin
        check("rd_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_total++;
        if (rd_data == e.data) n_pass++;
        else $display("FAIL rd_addr%0d: got %0d expected %0d",
                      e.addr, $signed(rd_data), $signed(e.data));
      end
    end
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int addr, input int exp_val);
    rd_en   = 1'b1;
    rd_addr = addr[NB_ADDR-1:0];
    sb.push_back('{8'(exp_val), addr});
    tick();
    rd_en = 1'b0;
  endtask

  task automatic arm_pulse(input int d);
    decim = d[NB_DECIM-1:0];
    arm   = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic send(input int s, input bit v, input bit trg);
    sample  = 8'(s);
    valid   = v;
    trigger = trg;
    tick();
    valid   = 1'b0;
    trigger = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sample = '0; valid = 0; arm = 0; trigger = 0;
    level = '0; decim = '0; rd_en = 0; rd_addr = '0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    tick();

`ifdef SIGNAL_CAPTURE_LEVEL_TRIG_EN
    // Rising crossing of 10 starts the window at sample 10
    level = 8'd10;
    arm_pulse(0);
    send(0, 1, 0); send(5, 1, 0); send(9, 1, 0);
    check("lvl_pre_count", wr_count, 0);
    send(10, 1, 0);
    check("lvl_trig_count", wr_count, 1);
    check("lvl_trig_busy", busy, 1);
    send(12, 1, 0);
    check("lvl_count2", wr_count, 2);
    do_read(0, 10);
    do_read(1, 12);
    // Already above threshold: no crossing, and i_trigger is ignored
    arm_pulse(0);
    send(12, 1, 1); send(11, 1, 1); send(15, 1, 1);
    check("lvl_notrig_count", wr_count, 0);
    check("lvl_notrig_busy", busy, 1);
    check("lvl_notrig_done", done, 0);
`else
    // Basic capture: ramp -8..7 fills the 16-deep window
    arm_pulse(0);
    check("arm_busy", busy, 1);
    check("arm_count", wr_count, 0);
    for (int i = 0; i < 15; i++) send(i - 8, 1, i == 0);
    check("basic_count15", wr_count, 15);
    check("basic_done15", done, 0);
    send(7, 1, 0);
    check("basic_count16", wr_count, 16);
    check("basic_done16", done, 1);
    check("basic_busy16", busy, 0);
    send(99, 1, 0);
    check("done_no_write", wr_count, 16);
    for (int a = 0; a < 16; a++) do_read(a, a - 8);

    // Decimation 1-of-3 with valid toggling
    arm_pulse(2);
    for (int i = 0; i < 15; i++) begin
      send(i, 1, i == 0);
      if (i == 3) check("decim_count_at3", wr_count, 2);
      send(-1, 0, 0);
    end
    check("decim_count", wr_count, 5);
    for (int a = 0; a < 5; a++) do_read(a, a * 3);

    // Abort mid-capture at count 7, then arm+trigger together
    arm_pulse(0);
    for (int i = 0; i < 7; i++) send(100 + i, 1, i == 0);
    check("abort_pre_count", wr_count, 7);
    sample = 8'd50; valid = 1; arm = 1;
    tick();
    arm = 0; valid = 0;
    check("abort_count", wr_count, 0);
    check("abort_busy", busy, 1);
    sample = 8'd77; valid = 1; arm = 1; trigger = 1;
    tick();
    arm = 0; valid = 0; trigger = 0;
    check("armtrig_count", wr_count, 0);
    check("armtrig_busy", busy, 1);
    check("armtrig_done", done, 0);
    do_read(0, 100);
    send(60, 1, 1);
    check("retrig_count", wr_count, 1);
    do_read(0, 60);

    // Read-during-write returns the old word
    arm_pulse(0);
    send(8'h10, 1, 1); send(8'h10, 1, 0); send(8'h10, 1, 0); send(8'h11, 1, 0);
    arm_pulse(0);
    send(8'h20, 1, 1); send(8'h21, 1, 0); send(8'h22, 1, 0);
    rd_en = 1; rd_addr = 4'd3;
    sb.push_back('{8'h11, 3});
    send(8'h55, 1, 0);
    rd_en = 0;
    do_read(3, 8'h55);

    // Reset mid-capture keeps memory contents
    arm_pulse(0);
    for (int i = 0; i < 12; i++) send(30 + i, 1, i == 0);
    check("prerst_count", wr_count, 12);
    rst = 1'b1;
    #1;
    check("asyncrst_busy", busy, 0);
    check("asyncrst_count", wr_count, 0);
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    check("postrst_busy", busy, 0);
    check("postrst_done", done, 0);
    check("postrst_count", wr_count, 0);
    check("postrst_rd_data", rd_data, 0);
    do_read(5, 35);
`endif

    tick(); tick(); tick();
    check("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
